// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the LED counter run-time controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    S_MANUAL    = 2'd0,
    S_BOUNCE_UP = 2'd1,
    S_BOUNCE_DN = 2'd2,
    S_CLEAR     = 2'd3
  } state_t;

  localparam logic [1:0] LED_MANUAL = 2'b00;
  localparam logic [1:0] LED_BOUNCE = 2'b01;
  localparam logic [1:0] LED_CLEAR  = 2'b10;

  localparam int         DEF_DB_CYCLES = 500000;
  localparam int         DEF_CLR_HOLD  = 65536;
  localparam logic [7:0] DEF_TOP       = 8'hFF;
  localparam logic [7:0] DEF_BOT       = 8'h00;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-count debounce and a
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int             CW   = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic          meta;
  logic          synced;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      meta   <= btn_raw;
      synced <= meta;
      press  <= 1'b0;
      // Any sample matching the accepted level restarts the stability count.
      if (synced != level) begin
        if (cnt == LAST) begin
          level <= synced;
          cnt   <= '0;
          press <= synced;
        end else begin
          cnt <= cnt + ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_counter_ctrl.sv
// Run-time controller for the LED counter datapath: debounced buttons drive
// rate select, direction, BOUNCE auto-reverse and a timed counter clear.
module led_counter_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int         DB_CYCLES = DEF_DB_CYCLES,
  parameter int         CLR_HOLD  = DEF_CLR_HOLD,
  parameter logic [7:0] TOP       = DEF_TOP,
  parameter logic [7:0] BOT       = DEF_BOT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_speed,
  input  logic       btn_dir,
  input  logic       btn_mode,
  input  logic       btn_clr,
  input  logic [7:0] cnt_val,
  output logic [1:0] sel,
  output logic       ud,
  output logic       cnt_clr,
  output logic [1:0] mode_led
);

  localparam int            TW   = $clog2(CLR_HOLD + 1);
  localparam logic [TW-1:0] LOAD = TW'(CLR_HOLD);
  localparam logic [TW-1:0] ONE  = TW'(1);

  logic speed_p, dir_p, mode_p, clr_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
    .clk(clk), .reset(reset), .btn_raw(btn_speed), .press(speed_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk(clk), .reset(reset), .btn_raw(btn_dir), .press(dir_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .reset(reset), .btn_raw(btn_mode), .press(mode_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .btn_raw(btn_clr), .press(clr_p));

  // cnt_val comes from the slow clock domain; a limit only counts once two
  // consecutive synchronised samples agree, so a mid-change sample is ignored.
  logic [7:0] cv_meta, cv_sync, cv_prev;
  logic       match_top, match_bot;

  always_ff @(posedge clk) begin
    if (reset) begin
      cv_meta <= '0;
      cv_sync <= '0;
      cv_prev <= '0;
    end else begin
      cv_meta <= cnt_val;
      cv_sync <= cv_meta;
      cv_prev <= cv_sync;
    end
  end

  assign match_top = (cv_sync == TOP) && (cv_prev == TOP);
  assign match_bot = (cv_sync == BOT) && (cv_prev == BOT);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          ret_bounce, ret_bounce_n;
  logic [1:0]    sel_n, led_n;
  logic          ud_n, cnt_clr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_MANUAL;
      timer      <= '0;
      ret_bounce <= 1'b0;
      sel        <= 2'b00;
      ud         <= 1'b1;
      cnt_clr    <= 1'b0;
      mode_led   <= LED_MANUAL;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      ret_bounce <= ret_bounce_n;
      sel        <= sel_n;
      ud         <= ud_n;
      cnt_clr    <= cnt_clr_n;
      mode_led   <= led_n;
    end
  end

  // Press priority clr > mode > dir; speed is applied in every state.
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    ret_bounce_n = ret_bounce;
    sel_n        = sel + {1'b0, speed_p};
    ud_n         = ud;
    cnt_clr_n    = cnt_clr;
    led_n        = mode_led;

    if (state != S_CLEAR && clr_p) begin
      state_n      = S_CLEAR;
      ret_bounce_n = (state != S_MANUAL);
      timer_n      = LOAD;
      cnt_clr_n    = 1'b1;
      led_n        = LED_CLEAR;
    end else begin
      case (state)
        S_MANUAL: begin
          if (mode_p) begin
            state_n = S_BOUNCE_UP;
            ud_n    = 1'b1;
            led_n   = LED_BOUNCE;
          end else if (dir_p) begin
            ud_n = ~ud;
          end
        end
        S_BOUNCE_UP: begin
          if (mode_p) begin
            state_n = S_MANUAL;
            led_n   = LED_MANUAL;
          end else if (match_top) begin
            state_n = S_BOUNCE_DN;
            ud_n    = 1'b0;
          end
        end
        S_BOUNCE_DN: begin
          if (mode_p) begin
            state_n = S_MANUAL;
            led_n   = LED_MANUAL;
          end else if (match_bot) begin
            state_n = S_BOUNCE_UP;
            ud_n    = 1'b1;
          end
        end
        S_CLEAR: begin
          if (timer == ONE) begin
            timer_n   = '0;
            cnt_clr_n = 1'b0;
            if (ret_bounce) begin
              state_n = S_BOUNCE_UP;
              ud_n    = 1'b1;
              led_n   = LED_BOUNCE;
            end else begin
              state_n = S_MANUAL;
              led_n   = LED_MANUAL;
            end
          end else begin
            timer_n = timer - ONE;
          end
        end
        default: state_n = S_MANUAL;
      endcase
    end
  end

endmodule
